// File: rtl/sat_adder_tree_pkg.sv
// Shared definitions for the saturating adder tree: default data width,
// signed clip limits and the saturating two-operand add used at every node.
// All arithmetic runs on SAT_W-bit sign-extended operands so one function
// serves any data width below SAT_W. The caller keeps only the low DW bits.
package sat_adder_tree_pkg;

  // Default channel data width. This matches the MAC accumulator width.
  localparam int DEFAULT_DW = 28;

  // Internal arithmetic width. Any DW used with the tree must be below this.
  localparam int SAT_W = 64;

  // Largest signed value representing in dw bits, sign-extended to SAT_W.
  function automatic logic signed [SAT_W-1:0] max_val(input int dw);
    logic signed [SAT_W-1:0] one;
    one = {{(SAT_W-1){1'b0}}, 1'b1};
    return (one <<< (dw - 1)) - one;
  endfunction

  // Smallest signed value representing in dw bits, sign-extended to SAT_W.
  function automatic logic signed [SAT_W-1:0] min_val(input int dw);
    logic signed [SAT_W-1:0] one;
    one = {{(SAT_W-1){1'b0}}, 1'b1};
    return -(one <<< (dw - 1));
  endfunction

  // Adds two dw-bit values that arrive sign-extended to SAT_W bits and clips
  // the result to the dw-bit range. The exact sum always fits in SAT_W bits,
  // so leaving the dw-bit range is the same event as a two's complement
  // overflow of a dw-bit adder. sat flags that the result was clipped.
  function automatic logic signed [SAT_W-1:0] sat_add(
    input  logic signed [SAT_W-1:0] a,
    input  logic signed [SAT_W-1:0] b,
    input  int                      dw,
    output logic                    sat
  );
    logic signed [SAT_W-1:0] s;
    logic signed [SAT_W-1:0] res;
    s   = a + b;
    res = s;
    sat = 1'b0;
    if (s > max_val(dw)) begin
      res = max_val(dw);
      sat = 1'b1;
    end else if (s < min_val(dw)) begin
      res = min_val(dw);
      sat = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/sat_add_level.sv
// One level of the saturating adder tree. The level has N_PAIRS saturating
// adders that feed a register stage. The stage also holds a valid bit and a
// sat bit.
// The stage loads only when adv is high. adv is high when the stage is empty
// or when the stage below it is advancing.
// With RELU set, this level loads zero instead of a negative sum.
module sat_add_level
  import sat_adder_tree_pkg::*;
#(
  parameter int N_PAIRS = 1,
  parameter int DW      = DEFAULT_DW,
  parameter bit RELU    = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear_adders,
  input  logic                    up_valid,
  input  logic                    up_sat,
  input  logic [2*N_PAIRS*DW-1:0] up_data,
  input  logic                    down_adv,
  output logic                    valid,
  output logic                    sat,
  output logic [N_PAIRS*DW-1:0]   data,
  output logic                    adv
);

  logic [N_PAIRS*DW-1:0] sum_flat;
  logic [N_PAIRS-1:0]    clip;

  for (genvar p = 0; p < N_PAIRS; p++) begin : g_pair
    logic [DW-1:0]           a_raw;
    logic [DW-1:0]           b_raw;
    logic signed [SAT_W-1:0] a_ext;
    logic signed [SAT_W-1:0] b_ext;
    logic signed [SAT_W-1:0] s_ext;
    logic [DW-1:0]           s_trunc;
    logic                    clip_p;
    logic                    unused_hi;

    assign a_raw = up_data[(2*p)*DW +: DW];
    assign b_raw = up_data[(2*p+1)*DW +: DW];
    assign a_ext = {{(SAT_W-DW){a_raw[DW-1]}}, a_raw};
    assign b_ext = {{(SAT_W-DW){b_raw[DW-1]}}, b_raw};

    // Saturating add of one channel pair.
    always_comb begin
      clip_p = 1'b0;
      s_ext  = sat_add(a_ext, b_ext, DW, clip_p);
    end

    // After clipping, the upper bits only repeat the sign bit.
    assign s_trunc   = s_ext[DW-1:0];
    assign unused_hi = ^s_ext[SAT_W-1:DW];

    assign sum_flat[p*DW +: DW] = (RELU && s_trunc[DW-1]) ? '0 : s_trunc;
    assign clip[p]              = clip_p;
  end

  assign adv = !valid || down_adv;

  // Stage register: reset and flush empty the stage; otherwise load on adv.
  always_ff @(posedge clk) begin
    if (reset || clear_adders) begin
      valid <= 1'b0;
      sat   <= 1'b0;
      data  <= '0;
    end else if (adv) begin
      valid <= up_valid;
      sat   <= up_valid & (up_sat | (|clip));
      if (up_valid) begin
        data <= sum_flat;
      end
    end
  end

endmodule

// File: rtl/sat_adder_tree.sv
// Fully pipelined saturating signed adder tree. It reduces NUM_IN channels
// of DW bits to one sum over LEVELS = log2(NUM_IN) register stages.
// Every adder clips to the DW-bit range. A clip anywhere in the tree sets
// the out_sat flag for that sample.
// Optional feature macro: SAT_ADDER_TREE_RELU_EN. When it is defined, the
// final stage loads zero instead of a negative sum.
//
// Handshake (both ports): a transfer happens on a rising edge where valid
// and ready are both high. A producer holds valid and data stable until the
// transfer. ready may depend combinationally on the downstream ready.
// reset and clear_adders force in_ready low and empty every stage.
module sat_adder_tree
  import sat_adder_tree_pkg::*;
#(
  parameter int NUM_IN = 8,
  parameter int DW     = DEFAULT_DW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear_adders,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NUM_IN*DW-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        out_sum,
  output logic                 out_sat
);

  localparam int LEVELS = $clog2(NUM_IN);

`ifdef SAT_ADDER_TREE_RELU_EN
  localparam bit RELU_EN = 1'b1;
`else
  localparam bit RELU_EN = 1'b0;
`endif

  logic [LEVELS-1:0] adv_vec;
  logic [LEVELS-1:0] valid_vec;
  logic [LEVELS-1:0] sat_vec;
  logic [DW-1:0]     last_data;

  for (genvar s = 0; s < LEVELS; s++) begin : g_level
    localparam int N_PAIRS = NUM_IN >> (s + 1);

    logic [2*N_PAIRS*DW-1:0] up_data;
    logic                    up_valid;
    logic                    up_sat;
    logic                    down_adv;
    logic [N_PAIRS*DW-1:0]   data;

    // Stage 0 takes its input from the port. The other stages take their
    // input from the stage above.
    if (s == 0) begin : g_first
      assign up_data  = in_data;
      assign up_valid = in_valid;
      assign up_sat   = 1'b0;
    end else begin : g_rest
      assign up_data  = g_level[s-1].data;
      assign up_valid = valid_vec[s-1];
      assign up_sat   = sat_vec[s-1];
    end

    // The last stage moves when the consumer takes the result. The other
    // stages move when the stage below them moves.
    if (s == LEVELS - 1) begin : g_last
      assign down_adv  = out_ready;
      assign last_data = data;
    end else begin : g_inner
      assign down_adv = adv_vec[s+1];
    end

    sat_add_level #(
      .N_PAIRS (N_PAIRS),
      .DW      (DW),
      .RELU    (RELU_EN && (s == LEVELS - 1))
    ) u_level (
      .clk          (clk),
      .reset        (reset),
      .clear_adders (clear_adders),
      .up_valid     (up_valid),
      .up_sat       (up_sat),
      .up_data      (up_data),
      .down_adv     (down_adv),
      .valid        (valid_vec[s]),
      .sat          (sat_vec[s]),
      .data         (data),
      .adv          (adv_vec[s])
    );
  end

  // No sample is accepted in a cycle that resets or flushes the pipeline.
  assign in_ready  = adv_vec[0] & ~reset & ~clear_adders;
  assign out_valid = valid_vec[LEVELS-1];
  assign out_sat   = sat_vec[LEVELS-1];
  assign out_sum   = last_data;

endmodule

// File: tb/tb_sat_adder_tree.sv
// Directed testbench for sat_adder_tree (NUM_IN=8, DW=28).
// Inputs change on the falling clock edge and outputs are sampled there too.
module tb_sat_adder_tree;

  localparam int NUM_IN = 8;
  localparam int DW     = 28;
  localparam int W      = NUM_IN * DW;

`ifdef SAT_ADDER_TREE_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          clear_adders;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_sum;
  logic          out_sat;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  sat_adder_tree #(.NUM_IN(NUM_IN), .DW(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .clear_adders (clear_adders),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_sat      (out_sat)
  );

  function automatic logic [W-1:0] fill(input logic [DW-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < NUM_IN; i++) r[i*DW +: DW] = v;
    return r;
  endfunction

  // Driver: called just after a falling edge. Holds the sample until it is
  // accepted, then returns at the falling edge after the accepting edge.
  task automatic send(input logic [W-1:0] d, output bit ok);
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (in_ready) begin
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  // Waits for out_valid, up to 20 cycles. lat counts the rising edges since
  // acceptance (1 on entry). lat is -1 if out_valid never rises.
  task automatic wait_out(output int lat, output logic [DW-1:0] s, output logic st);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    s  = out_sum;
    st = out_sat;
    if (!out_valid) lat = -1;
  endtask

  task automatic test_reset;
    reset        = 1'b1;
    clear_adders = 1'b0;
    in_valid     = 1'b1;
    in_data      = fill(28'd5);
    out_ready    = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    checks++;
    if (out_valid !== 1'b0 || out_sum !== '0 || out_sat !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b sum=%0h sat=%b expected 0/0/0", out_valid, out_sum, out_sat);
    end
    in_valid = 1'b0;
    reset    = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); end
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [W-1:0]  d;
    logic [DW-1:0] s;
    logic          st;
    int            lat;
    bit            ok;
    int            mix[NUM_IN] = '{100, -30, 7, -2, 0, 55, -1000, 3};
    for (int i = 0; i < NUM_IN; i++) d[i*DW +: DW] = DW'(i + 1);
    send(d, ok);
    wait_out(lat, s, st);
    checks++;
    if (lat != 3) begin errors++; $display("FAIL basic_latency: got %0d expected 3", lat); end
    checks++;
    if (s !== 28'd36 || st !== 1'b0) begin errors++; $display("FAIL basic_sum: got %0h sat %b expected 24 sat 0", s, st); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_one_cycle: got out_valid %b expected 0", out_valid); end
    // Mixed signs: the sum is -867.
    for (int i = 0; i < NUM_IN; i++) d[i*DW +: DW] = DW'(mix[i]);
    send(d, ok);
    wait_out(lat, s, st);
    checks++;
    if (s !== (RELU ? 28'h0 : 28'hFFFFC9D) || st !== 1'b0 || lat != 3) begin
      errors++;
      $display("FAIL mixed_sum: got %0h sat %b lat %0d expected %0h sat 0 lat 3", s, st, lat, RELU ? 28'h0 : 28'hFFFFC9D);
    end
    @(negedge clk);
  endtask

  task automatic test_clip;
    logic [DW-1:0] s;
    logic          st;
    int            lat;
    bit            ok;
    send(fill(28'h4000000), ok);
    send(fill(28'h8000000), ok);
    wait_out(lat, s, st);
    checks++;
    if (s !== 28'h7FFFFFF || st !== 1'b1) begin errors++; $display("FAIL pos_clip: got %0h sat %b expected 7ffffff sat 1", s, st); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== (RELU ? 28'h0 : 28'h8000000) || out_sat !== 1'b1) begin
      errors++;
      $display("FAIL neg_clip: got v=%b %0h sat %b expected v=1 %0h sat 1", out_valid, out_sum, out_sat, RELU ? 28'h0 : 28'h8000000);
    end
    @(negedge clk);
  endtask

  task automatic test_relu;
    logic [W-1:0]  d;
    logic [DW-1:0] s;
    logic          st;
    int            lat;
    bit            ok;
    d = '0;
    d[DW-1:0] = 28'hFFFFFFB;
    send(d, ok);
    wait_out(lat, s, st);
    checks++;
    if (s !== (RELU ? 28'h0 : 28'hFFFFFFB) || st !== 1'b0 || lat != 3) begin
      errors++;
      $display("FAIL relu_minus5: got %0h sat %b lat %0d expected %0h sat 0 lat 3", s, st, lat, RELU ? 28'h0 : 28'hFFFFFFB);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int            next_k = 1;
    int            pushed = 0;
    int            popped = 0;
    bit            held   = 1'b0;
    logic [DW-1:0] held_sum = '0;
    logic [DW-1:0] e;
    int            stable_bad = 0;
    exp_q.delete();
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (held && (out_valid !== 1'b1 || out_sum !== held_sum)) begin
        stable_bad++;
        $display("FAIL stall_stable: got v=%b %0h expected v=1 %0h", out_valid, out_sum, held_sum);
      end
      out_ready = !(cyc >= 4 && cyc < 10);
      in_valid  = (next_k <= 10);
      in_data   = fill(DW'(next_k));
      #1;
      if (cyc == 9) begin
        checks++;
        if (in_ready !== 1'b0 || pushed - popped != 3) begin
          errors++;
          $display("FAIL stall_full: got in_ready %b buffered %0d expected 0 and 3", in_ready, pushed - popped);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra: got %0h expected no result", out_sum);
        end else begin
          e = exp_q.pop_front();
          if (out_sum !== e || out_sat !== 1'b0) begin
            errors++;
            $display("FAIL b2b_order: got %0h sat %b expected %0h sat 0", out_sum, out_sat, e);
          end
        end
        popped++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(DW'(8 * next_k));
        pushed++;
        next_k++;
      end
      held     = out_valid && !out_ready;
      held_sum = out_sum;
      @(negedge clk);
      if (popped == 10) break;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (popped != 10 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_count: got %0d results %0d pending expected 10 and 0", popped, exp_q.size());
    end
    checks++;
    if (stable_bad != 0) begin errors++; $display("FAIL stall_stable_total: got %0d unstable cycles expected 0", stable_bad); end
    @(negedge clk);
  endtask

  task automatic test_flush;
    bit ok;
    int stale = 0;
    out_ready = 1'b0;
    send(fill(28'd2), ok);
    send(fill(28'd3), ok);
    send(fill(28'd4), ok);
    clear_adders = 1'b1;
    in_valid     = 1'b1;
    in_data      = fill(28'd9);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b expected 0", in_ready); end
    @(negedge clk);
    clear_adders = 1'b0;
    in_valid     = 1'b0;
    out_ready    = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || out_sat !== 1'b0) begin
      errors++;
      $display("FAIL flush_empty: got v=%b sat=%b expected 0/0", out_valid, out_sat);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    checks++;
    if (stale != 0) begin errors++; $display("FAIL flush_stale: got %0d results expected 0", stale); end
  endtask

  task automatic test_reset_clear;
    logic [W-1:0]  d;
    logic [DW-1:0] s;
    logic          st;
    int            lat;
    bit            ok;
    out_ready = 1'b0;
    send(fill(28'd1), ok);
    send(fill(28'd2), ok);
    send(fill(28'd3), ok);
    reset        = 1'b1;
    clear_adders = 1'b1;
    in_valid     = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL rc_in_ready: got %b expected 0", in_ready); end
    @(negedge clk);
    reset        = 1'b0;
    clear_adders = 1'b0;
    in_valid     = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_sum !== '0 || out_sat !== 1'b0) begin
      errors++;
      $display("FAIL rc_outputs: got v=%b sum=%0h sat=%b expected 0/0/0", out_valid, out_sum, out_sat);
    end
    out_ready = 1'b1;
    for (int i = 0; i < NUM_IN; i++) d[i*DW +: DW] = DW'((i + 1) * 10);
    send(d, ok);
    wait_out(lat, s, st);
    checks++;
    if (s !== 28'd360 || st !== 1'b0 || lat != 3) begin
      errors++;
      $display("FAIL rc_fresh: got %0h sat %b lat %0d expected 168 sat 0 lat 3", s, st, lat);
    end
    @(negedge clk);
  endtask

  initial begin
    reset        = 1'b1;
    clear_adders = 1'b0;
    in_valid     = 1'b0;
    in_data      = '0;
    out_ready    = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_clip();
    test_relu();
    test_back_to_back();
    test_flush();
    test_reset_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
